// File: rtl/gen1_mem_responder.sv
// gen1 core memory bus responder: word read/write/fetch from on-chip RAM with programmable
// wait states, a write-protected low region, and busx/busxa bus exception signalling.
module gen1_mem_responder #(
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter int unsigned           RAM_WORDS   = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int unsigned           ROM_WORDS   = 256,
    parameter int unsigned           WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] xaddr,
    input  logic [31:0]           xdout,
    output logic [31:0]           xdin,
    input  logic                  memexec,
    input  logic                  memread,
    input  logic                  memwrite,
    output logic                  memready,
    output logic                  busx,
    input  logic                  busxa,
    output logic [ADDR_WIDTH-1:0] fault_addr
);

    localparam int unsigned IDX_W = $clog2(RAM_WORDS);
    localparam int unsigned CNT_W = 4;

    // Elaboration-time parameter sanity checks.
    if (WAIT_STATES > 15) begin : g_bad_wait_states
        $error("WAIT_STATES must be in 0..15");
    end
    if (RAM_WORDS < 2 || (RAM_WORDS & (RAM_WORDS - 1)) != 0) begin : g_bad_ram_words
        $error("RAM_WORDS must be a power of two >= 2");
    end
    if (ADDR_WIDTH <= IDX_W + 2) begin : g_bad_addr_width
        $error("ADDR_WIDTH too narrow for RAM_WORDS");
    end

    // StEval is the extra cycle in which the registered RAM read data becomes available.
    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StEval,
        StDone
    } state_e;

    state_e                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [31:0]           rdata_q;
    logic                  rd_q;
    logic                  wr_q;
    logic                  ex_q;

    logic [31:0] mem [RAM_WORDS];

    logic                  req;
    logic [ADDR_WIDTH-1:0] offset;
    logic [IDX_W-1:0]      idx;
    logic                  misaligned;
    logic                  out_of_range;
    logic                  rom_hit;
    logic                  bad_cmd;
    logic                  fault;

    // Request detect and fault decode of the latched access.
    always_comb begin
        req          = memread | memwrite;
        offset       = addr_q - BASE_ADDR;
        idx          = offset[IDX_W+1:2];
        // BASE_ADDR is aligned, so the offset's low bits equal the address's low bits.
        misaligned   = offset[1:0] != 2'b00;
        // No aliasing: any offset bit above the RAM window puts the access out of range.
        out_of_range = (addr_q < BASE_ADDR) || (offset[ADDR_WIDTH-1:IDX_W+2] != '0);
        rom_hit      = wr_q && (ROM_WORDS != 0) && (32'(idx) < ROM_WORDS);
        bad_cmd      = (rd_q && wr_q) || (ex_q && wr_q);
        fault        = misaligned | out_of_range | rom_hit | bad_cmd;
    end

    // RAM port: read as the access leaves WAIT, write on the edge that enters DONE.
    always_ff @(posedge clk) begin
        if (state_q == StWait && cnt_q == '0) begin
            rdata_q <= mem[idx];
        end
        if (!reset && state_q == StEval && wr_q && !fault) begin
            mem[idx] <= wdata_q;
        end
    end

    // Access sequencer with registered bus outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            ex_q       <= 1'b0;
            memready   <= 1'b0;
            busx       <= 1'b0;
            xdin       <= '0;
            fault_addr <= '0;
        end else begin
            // Master acknowledge drops busx in any state; later assignments below take priority.
            if (busx && busxa) begin
                busx <= 1'b0;
            end
            unique case (state_q)
                StIdle: begin
                    if (req) begin
                        addr_q  <= xaddr;
                        wdata_q <= xdout;
                        rd_q    <= memread;
                        wr_q    <= memwrite;
                        ex_q    <= memexec;
                        cnt_q   <= CNT_W'(WAIT_STATES);
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (cnt_q == '0) begin
                        state_q <= StEval;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StEval: begin
                    memready <= 1'b1;
                    state_q  <= StDone;
                    if (fault) begin
                        busx       <= 1'b1;
                        xdin       <= '0;
                        fault_addr <= addr_q;
                    end else if (rd_q) begin
                        xdin <= rdata_q;
                    end else begin
                        xdin <= '0;
                    end
                end
                StDone: begin
                    if (!req) begin
                        memready <= 1'b0;
                        busx     <= 1'b0;
                        xdin     <= '0;
                        state_q  <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_gen1_mem_responder.sv
// Scoreboard bench for gen1_mem_responder: one instance with one wait state, one with none.
module tb_gen1_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic [31:0] xaddr;
    logic [31:0] xdout;
    logic        memread;
    logic        memwrite;
    logic        memexec;
    logic        busxa;

    logic [31:0] xdin1, xdin0, fa1, fa0;
    logic        rdy1, rdy0, bx1, bx0;
    logic [31:0] xdin_m, fa_m;
    logic        memready_m, busx_m;

    assign memready_m = sel ? rdy0 : rdy1;
    assign busx_m     = sel ? bx0 : bx1;
    assign xdin_m     = sel ? xdin0 : xdin1;
    assign fa_m       = sel ? fa0 : fa1;

    gen1_mem_responder #(
        .ADDR_WIDTH (32),
        .RAM_WORDS  (1024),
        .BASE_ADDR  (32'h0),
        .ROM_WORDS  (256),
        .WAIT_STATES(1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .xaddr     (xaddr),
        .xdout     (xdout),
        .xdin      (xdin1),
        .memexec   (memexec & ~sel),
        .memread   (memread & ~sel),
        .memwrite  (memwrite & ~sel),
        .memready  (rdy1),
        .busx      (bx1),
        .busxa     (busxa & ~sel),
        .fault_addr(fa1)
    );

    gen1_mem_responder #(
        .ADDR_WIDTH (32),
        .RAM_WORDS  (1024),
        .BASE_ADDR  (32'h0),
        .ROM_WORDS  (256),
        .WAIT_STATES(0)
    ) dut0 (
        .clk       (clk),
        .reset     (reset),
        .xaddr     (xaddr),
        .xdout     (xdout),
        .xdin      (xdin0),
        .memexec   (memexec & sel),
        .memread   (memread & sel),
        .memwrite  (memwrite & sel),
        .memready  (rdy0),
        .busx      (bx0),
        .busxa     (busxa & sel),
        .fault_addr(fa0)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       name;
        logic        bx;
        logic        chk_d;
        logic [31:0] d;
        logic [31:0] fa;
        int          rc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] last_fault [2];
    logic        rdy_prev = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every rising memready must match the oldest expected response.
    always @(negedge clk) begin
        if (reset) begin
            rdy_prev <= 1'b0;
        end else begin
            if (memready_m && !rdy_prev) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_memready: got 1, want 0");
                end else begin
                    mon_e = sb.pop_front();
                    chk({mon_e.name, "_busx"}, 64'(busx_m), 64'(mon_e.bx));
                    if (mon_e.chk_d) chk({mon_e.name, "_xdin"}, 64'(xdin_m), 64'(mon_e.d));
                    chk({mon_e.name, "_fault_addr"}, 64'(fa_m), 64'(mon_e.fa));
                    chk({mon_e.name, "_latency"}, 64'(cyc), 64'(mon_e.rc));
                end
            end
            rdy_prev <= memready_m;
        end
    end

    // Drives one four-phase access starting at a negedge and queues its expected response.
    task automatic access(input string name, input logic [31:0] a, input logic [31:0] d,
                          input logic r, input logic w, input logic x,
                          input logic exp_bx, input logic [31:0] exp_d, input bit pulse_xa);
        exp_t e;
        bit   seen;
        if (exp_bx) last_fault[sel] = a;
        e.name  = name;
        e.bx    = exp_bx;
        e.chk_d = exp_bx || (r && !w);
        e.d     = exp_bx ? 32'h0 : exp_d;
        e.fa    = last_fault[sel];
        e.rc    = cyc + (sel ? 0 : 1) + 3;
        sb.push_back(e);
        xaddr = a; xdout = d; memread = r; memwrite = w; memexec = x;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = memready_m;
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: memready 0 after 40 cycles, want 1", name);
            sb.delete();
        end
        @(negedge clk);
        chk({name, "_held"}, 64'({memready_m, busx_m}), 64'({1'b1, exp_bx}));
        if (pulse_xa) begin
            busxa = 1'b1;
            @(negedge clk);
            busxa = 1'b0;
            chk({name, "_busxa"}, 64'({memready_m, busx_m, xdin_m}), 64'({1'b1, 1'b0, e.d}));
        end
        memread = 1'b0; memwrite = 1'b0; memexec = 1'b0;
        @(negedge clk);
        chk({name, "_drop"}, 64'({memready_m, busx_m, xdin_m}), 64'({1'b0, 1'b0, 32'h0}));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        sel = 1'b0; reset = 1'b1; xaddr = '0; xdout = '0;
        memread = 1'b0; memwrite = 1'b0; memexec = 1'b0; busxa = 1'b0;
        last_fault[0] = '0;
        last_fault[1] = '0;
        dut.mem[4]    = 32'hDEADBEEF;
        dut.mem[64]   = 32'hCAFEF00D;
        dut0.mem[4]   = 32'hDEADBEEF;
        dut0.mem[255] = 32'h11112222;
        repeat (3) @(negedge clk);
        chk("reset_ws1", 64'({rdy1, bx1, xdin1, fa1}), 64'h0);
        chk("reset_ws0", 64'({rdy0, bx0, xdin0, fa0}), 64'h0);
        reset = 1'b0;
        @(negedge clk);

        // T1: plain read with one wait state
        access("t1_rd10", 32'h10, 32'h0, 1, 0, 0, 0, 32'hDEADBEEF, 0);
        // T2: write/readback, protected region, last word
        access("t2_wr800", 32'h800, 32'h12345678, 0, 1, 0, 0, 32'h0, 0);
        access("t2_rd800", 32'h800, 32'h0, 1, 0, 0, 0, 32'h12345678, 0);
        access("t2_wr_rom", 32'h100, 32'hAAAA5555, 0, 1, 0, 1, 32'h0, 0);
        access("t2_rd_rom", 32'h100, 32'h0, 1, 0, 0, 0, 32'hCAFEF00D, 0);
        access("t2_wr_last", 32'hFFC, 32'h5A5A0001, 0, 1, 0, 0, 32'h0, 0);
        access("t2_rd_last", 32'hFFC, 32'h0, 1, 0, 0, 0, 32'h5A5A0001, 0);
        // T3: misaligned and out of range
        access("t3_misalign", 32'h2, 32'h0, 1, 0, 0, 1, 32'h0, 0);
        access("t3_range", 32'h1000, 32'h0, 1, 0, 0, 1, 32'h0, 0);
        // T4: busxa clears a held fault; busxa without busx is ignored
        access("t4_busxa_fault", 32'h3, 32'h0, 1, 0, 0, 1, 32'h0, 1);
        access("t4_busxa_nofault", 32'h10, 32'h0, 1, 0, 0, 0, 32'hDEADBEEF, 1);
        // T5: illegal command combinations, memexec alone, fetch
        access("t5_rdwr", 32'h804, 32'h1, 1, 1, 0, 1, 32'h0, 0);
        memexec = 1'b1;
        repeat (5) @(negedge clk);
        chk("t5_exec_only", 64'(memready_m), 64'h0);
        memexec = 1'b0;
        access("t5_exec_wr", 32'h808, 32'h2, 0, 1, 1, 1, 32'h0, 0);
        access("t5_fetch", 32'h10, 32'h0, 1, 0, 1, 0, 32'hDEADBEEF, 0);
        // T6: reset during WAIT aborts a write
        xaddr = 32'h800; xdout = 32'hFFFF0000; memwrite = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("t6_abort_outputs", 64'({rdy1, bx1, xdin1, fa1}), 64'h0);
        reset = 1'b0; memwrite = 1'b0;
        last_fault[0] = '0;
        last_fault[1] = '0;
        @(negedge clk);
        access("t6_rd800_kept", 32'h800, 32'h0, 1, 0, 0, 0, 32'h12345678, 0);
        // T6: zero wait states, back-to-back handshakes
        sel = 1'b1;
        @(negedge clk);
        access("t6_ws0_rd10", 32'h10, 32'h0, 1, 0, 0, 0, 32'hDEADBEEF, 0);
        access("t6_ws0_wr_rom_top", 32'h3FC, 32'h77777777, 0, 1, 0, 1, 32'h0, 0);
        access("t6_ws0_wr400", 32'h400, 32'h0BADF00D, 0, 1, 0, 0, 32'h0, 0);
        access("t6_ws0_rd400", 32'h400, 32'h0, 1, 0, 0, 0, 32'h0BADF00D, 0);
        access("t6_ws0_rd3fc", 32'h3FC, 32'h0, 1, 0, 0, 0, 32'h11112222, 0);

        repeat (3) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
